dram_line_xfer: RTL

Line-transfer sequencer between the cache controller and the ideal single-word DRAM model. It accepts one 4-word (16-byte) line fill or writeback request and issues the required aligned 32-bit word accesses to the DRAM port. It can insert programmable wait states between accesses, assembles read words into a 128-bit line, and returns one completion pulse per request. The cache sees line-granular transactions; the DRAM sees only aligned word accesses.

---
 rtl/dram_line_xfer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dram_line_xfer.sv
// rtl/dram_line_xfer.sv - 4-word line fill/writeback sequencer onto a single-word DRAM port
// Optional build macro: DRAM_XFER_CRITICAL_WORD_FIRST_EN (fills start at the requested word and wrap)
module dram_line_xfer #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_wr_i,
    input  logic [15:0]  req_addr_i,
    input  logic [127:0] req_wdata_i,
    output logic         resp_valid_o,
    output logic [127:0] resp_rdata_o,
    output logic         resp_err_o,
    output logic         busy_o,
    output logic         mem_en_o,
    output logic         mem_wr_o,
    output logic [15:0]  mem_addr_o,
    output logic [31:0]  mem_wdata_o,
    input  logic [31:0]  mem_rdata_i,
    input  logic         mem_err_i
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

    localparam int         WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] WAIT_INIT = WAIT_LOAD[3:0];
    localparam state_t     GAP_STATE = (WAIT_CYCLES > 0) ? S_WAIT : S_XFER;

    state_t       state_q;
    logic         wr_q;
    logic [11:0]  base_q;
    logic [127:0] wdata_q;
    logic [127:0] line_q;
    logic [1:0]   word_q;
    logic [1:0]   cnt_q;
    logic [3:0]   wait_q;
    logic         err_q;

    logic [1:0]   start_word_d;
    logic [1:0]   word_d;
    logic [6:0]   slot_d;
    logic         xfer_d;

`ifdef DRAM_XFER_CRITICAL_WORD_FIRST_EN
    // Writebacks always go out in natural order; only fills honour the critical word.
    assign start_word_d = req_wr_i ? 2'd0 : req_addr_i[3:2];
    logic unused_addr;
    assign unused_addr = ^req_addr_i[1:0];
`else
    assign start_word_d = 2'd0;
    logic unused_addr;
    assign unused_addr = ^req_addr_i[3:0];
`endif

    assign word_d = word_q + 2'd1;
    assign slot_d = {word_q, 5'd0};
    assign xfer_d = (state_q == S_XFER);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            base_q  <= 12'd0;
            wdata_q <= 128'd0;
            line_q  <= 128'd0;
            word_q  <= 2'd0;
            cnt_q   <= 2'd0;
            wait_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        wr_q    <= req_wr_i;
                        base_q  <= req_addr_i[15:4];
                        wdata_q <= req_wdata_i;
                        word_q  <= start_word_d;
                        cnt_q   <= 2'd0;
                        wait_q  <= WAIT_INIT;
                        err_q   <= 1'b0;
                        state_q <= GAP_STATE;
                    end
                end
                S_WAIT: begin
                    if (wait_q == 4'd0) begin
                        state_q <= S_XFER;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                S_XFER: begin
                    err_q <= err_q | mem_err_i;
                    if (!wr_q) begin
                        line_q[slot_d +: 32] <= mem_rdata_i;
                    end
                    // cnt_q counts completed accesses, so 3 here means this is the fourth.
                    if (cnt_q == 2'd3) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q + 2'd1;
                        word_q  <= word_d;
                        wait_q  <= WAIT_INIT;
                        state_q <= GAP_STATE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = (state_q == S_IDLE) && !rst_i;
    assign busy_o       = (state_q != S_IDLE);
    assign resp_valid_o = (state_q == S_DONE);
    assign resp_err_o   = (state_q == S_DONE) && err_q;
    assign resp_rdata_o = line_q;

    assign mem_en_o    = xfer_d;
    assign mem_wr_o    = xfer_d && wr_q;
    assign mem_addr_o  = xfer_d ? {base_q, word_q, 2'b00} : 16'd0;
    assign mem_wdata_o = (xfer_d && wr_q) ? wdata_q[slot_d +: 32] : 32'd0;

endmodule
